reflet_poly_synth: RTL and testbench

Multi-voice square-wave synthesiser peripheral for the reflet microcontroller. It generalises the single-voice `synth` slot of `reflet_peripheral` to a parametrised number of voices, each with its own 16-bit pitch divider, 4-bit volume and phase restart. The voices are mixed digitally and driven onto one pin through a first-order sigma-delta modulator. The block sits on the byte-wide peripheral bus and returns zero when not addressed, so its read data can be OR-ed with the rest of the bus.

---
 rtl/reflet_poly_synth.sv | 88 ++++++++
 tb/tb_reflet_poly_synth.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_poly_synth.sv
// reflet_poly_synth: multi-voice square-wave synthesiser with a sigma-delta output on the byte-wide peripheral bus
module reflet_poly_synth #(
  parameter int voices = 4,
  parameter int addr_size = 15,
  parameter logic [addr_size-1:0] base_addr = 15'h7F40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 write_en,
  output logic                 synth_out
);
  localparam int W = 4 + $clog2(voices);
  localparam int AW = $clog2(4 * voices);
  logic [15:0]    r_hp  [voices];
  logic           r_en  [voices];
  logic [3:0]     r_vol [voices];
  logic [15:0]    r_cnt [voices];
  logic           r_lvl [voices];
  logic [W-1:0]   r_acc;
  logic           r_out;
  logic           w_sel;
  logic           w_we;
  logic [AW-1:0]  w_off;
  logic [voices-1:0] w_hit;
  logic [W-1:0]   w_sample;
  logic [7:0]     w_rd;
  assign w_off = addr[AW-1:0];
  assign w_sel = enable && (addr[addr_size-1:AW] == base_addr[addr_size-1:AW]);
  assign w_we = w_sel && write_en;
  assign data_out = w_rd;
  assign synth_out = r_out;
  // per-voice select: each voice owns four consecutive bytes
  always_comb begin
    w_hit = '0;
    for (int v = 0; v < voices; v++) w_hit[v] = w_sel && ((w_off >> 2) == AW'(v));
  end
  // mixer: add the volume of every voice whose level is high; cannot overflow W bits
  always_comb begin
    w_sample = '0;
    for (int v = 0; v < voices; v++) w_sample = w_sample + (r_lvl[v] ? W'(r_vol[v]) : W'(0));
  end
  // read mux from registered state; zero when the block is not addressed
  always_comb begin
    w_rd = '0;
    for (int v = 0; v < voices; v++)
      if (w_hit[v])
        w_rd = w_off[1:0] == 2'd0 ? r_hp[v][7:0] :
               w_off[1:0] == 2'd1 ? r_hp[v][15:8] :
               w_off[1:0] == 2'd2 ? {r_vol[v], 3'b000, r_en[v]} : {7'b0, r_lvl[v]};
  end
  // register writes, voice dividers and first-order sigma-delta modulator
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < voices; v++) begin
        r_hp[v]  <= '0;
        r_en[v]  <= 1'b0;
        r_vol[v] <= '0;
        r_cnt[v] <= '0;
        r_lvl[v] <= 1'b0;
      end
      r_acc <= '0;
      r_out <= 1'b0;
    end else begin
      for (int v = 0; v < voices; v++) begin
        if (w_we && w_hit[v] && w_off[1:0] == 2'd0) r_hp[v][7:0] <= data_in;
        if (w_we && w_hit[v] && w_off[1:0] == 2'd1) r_hp[v][15:8] <= data_in;
        if (w_we && w_hit[v] && w_off[1:0] == 2'd2) begin
          r_en[v]  <= data_in[0];
          r_vol[v] <= data_in[7:4];
        end
        if (!r_en[v] || r_hp[v] == 16'd0 || (w_we && w_hit[v] && w_off[1:0] == 2'd2 && data_in[1])) begin
          r_cnt[v] <= '0;
          r_lvl[v] <= 1'b0;
        end else if (r_cnt[v] >= r_hp[v] - 16'd1) begin
          r_cnt[v] <= '0;
          r_lvl[v] <= ~r_lvl[v];
        end else begin
          r_cnt[v] <= r_cnt[v] + 16'd1;
        end
      end
      {r_out, r_acc} <= {1'b0, r_acc} + {1'b0, w_sample};
    end
  end
endmodule

// File: tb/tb_reflet_poly_synth.sv
// tb_reflet_poly_synth: directed self-checking bench for the multi-voice synthesiser
module tb_reflet_poly_synth;
  localparam logic [14:0] B = 15'h7F40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [14:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic write_en = 1'b0;
  logic synth_out;
  int checks = 0;
  int errors = 0;

  reflet_poly_synth #(.voices(4), .addr_size(15), .base_addr(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .data_out(data_out), .write_en(write_en), .synth_out(synth_out)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1;
    write_en = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    enable = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [7:0] d);
    @(negedge clk);
    enable = 1'b1;
    write_en = 1'b0;
    addr = a;
    #1;
    d = data_out;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int highs;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rd(B + 15'(i), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_read off=%0d got=%h exp=00", i, d);
      end
    end
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (synth_out !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL reset_synth_out highs=%0d exp=0", highs);
    end
  endtask

  task automatic test_pitch();
    int highs;
    logic exp;
    do_reset();
    wr(B, 8'h04);
    wr(B + 15'd2, 8'hF1);
    enable = 1'b1;
    addr = B + 15'd3;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp = ((k >> 2) & 1) != 0;
      checks++;
      if (data_out !== {7'b0, exp}) begin
        errors++;
        $display("FAIL pitch_level k=%0d got=%h exp=%0d", k, data_out, exp);
      end
    end
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (synth_out === 1'b1) highs++;
    end
    checks++;
    if (highs < 119 || highs > 121) begin
      errors++;
      $display("FAIL pitch_duty highs=%0d exp=120+-1", highs);
    end
  endtask

  task automatic test_shrink();
    logic exp;
    do_reset();
    wr(B, 8'h10);
    wr(B + 15'd2, 8'hF1);
    repeat (10) @(posedge clk);
    wr(B, 8'h03);
    enable = 1'b1;
    addr = B + 15'd3;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp = (k == 0) ? 1'b0 : ((((k - 1) / 3) % 2) == 0);
      checks++;
      if (data_out !== {7'b0, exp}) begin
        errors++;
        $display("FAIL shrink_level k=%0d got=%h exp=%0d", k, data_out, exp);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_restart();
    logic [7:0] d;
    logic exp;
    do_reset();
    wr(B, 8'h07);
    wr(B + 15'd4, 8'h07);
    wr(B + 15'd2, 8'hF1);
    repeat (2) @(posedge clk);
    wr(B + 15'd6, 8'hF1);
    repeat (10) @(posedge clk);
    wr(B + 15'd2, 8'hF3);
    wr(B + 15'd6, 8'hF3);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      enable = 1'b1;
      addr = (k < 14) ? B + 15'd3 : B + 15'd7;
      #1;
      exp = (k < 14) ? ((((k + 1) / 7) % 2) != 0) : (((k / 7) % 2) != 0);
      checks++;
      if (data_out !== {7'b0, exp}) begin
        errors++;
        $display("FAIL restart_level k=%0d got=%h exp=%0d", k, data_out, exp);
      end
    end
    enable = 1'b0;
    rd(B + 15'd2, d);
    checks++;
    if (d !== 8'hF1) begin
      errors++;
      $display("FAIL restart_ctrl_read got=%h exp=f1", d);
    end
  endtask

  task automatic test_full_scale();
    logic [7:0] d;
    int highs;
    do_reset();
    for (int v = 0; v < 4; v++) wr(B + 15'(4 * v), 8'd200);
    for (int v = 0; v < 4; v++) wr(B + 15'(4 * v + 2), 8'hF1);
    repeat (205) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (synth_out === 1'b1) highs++;
    end
    checks++;
    if (highs !== 60) begin
      errors++;
      $display("FAIL full_scale_duty highs=%0d exp=60", highs);
    end
    for (int v = 0; v < 4; v += 3) begin
      rd(B + 15'(4 * v + 3), d);
      checks++;
      if (d !== 8'h01) begin
        errors++;
        $display("FAIL full_scale_level v=%0d got=%h exp=01", v, d);
      end
    end
  endtask

  task automatic test_isolation_reset();
    logic [7:0] d;
    do_reset();
    wr(B, 8'h05);
    wr(B + 15'd2, 8'hF1);
    repeat (20) @(posedge clk);
    wr(B + 15'd16, 8'hFF);
    rd(B + 15'd16, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL outside_read got=%h exp=00", d);
    end
    @(negedge clk);
    enable = 1'b0;
    write_en = 1'b1;
    addr = B;
    data_in = 8'hAA;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    wr(B + 15'd3, 8'hFF);
    rd(B, d);
    checks++;
    if (d !== 8'h05) begin
      errors++;
      $display("FAIL iso_hp_lo got=%h exp=05", d);
    end
    rd(B + 15'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL iso_hp_hi got=%h exp=00", d);
    end
    rd(B + 15'd2, d);
    checks++;
    if (d !== 8'hF1) begin
      errors++;
      $display("FAIL iso_ctrl got=%h exp=f1", d);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (synth_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_synth_out got=%b exp=0", synth_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int v = 0; v < 4; v++) begin
      rd(B + 15'(4 * v + 3), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset_status v=%0d got=%h exp=00", v, d);
      end
    end
    rd(B + 15'd2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_ctrl got=%h exp=00", d);
    end
  endtask

  initial begin
    test_reset();
    test_pitch();
    test_shrink();
    test_restart();
    test_full_scale();
    test_isolation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
